water_level_display: RTL
========================

Name: water_level_display

Overview:
Display-side decoder for the 2-bit encoded water level: 00 = Critical, 01 = Low, 10 = Mid, 11 = High.
- Filters the code so a value is accepted only after it holds for a programmable number of consecutive clocks. This rejects sensor-transition glitches.
- Drives a 7-segment digit and one-hot level lines from the accepted value.
- Blinks the digit and raises a steady alarm while the accepted level is Critical.
- Sits between the water encoder and the board display / pump controller.

Parameters:
STABLE_CYCLES, 4, consecutive identical samples required to accept a code (>=1).
BLINK_HALF, 25000000, clock cycles per blink half-period in Critical (>=1).

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
encoded_water  input  2  encoded level from the encoder, sampled every rising edge.
segments  output  7  active-low 7-seg pattern, bit order {g,f,e,d,c,b,a}.
level  output  2  last accepted level code.
level_onehot  output  4  bit i = valid and level==i.
valid  output  1  high once any code has been accepted since reset.
changed  output  1  one-cycle pulse when level is updated.
alarm  output  1  valid and level==00, steady (no blink).

Behaviour:
- Reset values (asynchronous, immediate on assertion):
  - level=00, valid=0, changed=0, alarm=0, level_onehot=0000, segments=1111111 (blank).
  - Internal: candidate=00, run count=0, blink counter=0, blink phase=0.
- Filter, evaluated every edge:
  - next_run = (encoded_water==candidate) ? run+1 : 1, saturating at STABLE_CYCLES.
  - candidate <= encoded_water.
  - Accept when next_run >= STABLE_CYCLES and (!valid or encoded_water != level). On accept: level <= encoded_water, valid <= 1, changed <= 1 for exactly one cycle.
  - Accept happens on the STABLE_CYCLES-th consecutive equal sample. Outputs reflect it after that edge.
  - Holding an already-accepted value never re-pulses changed.
  - The first post-reset sample of 00 counts as run 1, because candidate resets to 00.
- A code differing from level that holds fewer than STABLE_CYCLES samples is ignored. level is unchanged and no pulse is produced.
- Segment decode (combinational from registered state):
  - !valid: 1111111.
  - Level 1: 1111001. Level 2: 0100100. Level 3: 0110000.
  - Level 0: 1000000 when blink phase=0, 1111111 when phase=1.
- Blink:
  - Active only while valid and level==00.
  - Counter counts 0..BLINK_HALF-1. At terminal count it wraps to 0 and phase toggles.
  - On the accept edge entering Critical, counter=0 and phase=0, so the digit is first shown lit for BLINK_HALF cycles.
  - Outside Critical, counter and phase are held at 0.
- alarm and level_onehot are combinational from level/valid and never blink.
- Simultaneous accept and blink wrap: accept takes priority and the blink state reloads to 0/0.
- Reset mid-settle or mid-blink: all state clears. After release, a full STABLE_CYCLES run is required before valid rises.
- Counter widths: $clog2 of the parameter + 1. No overflow is permitted at any parameter value >=1.

Test Plan (STABLE_CYCLES=4, BLINK_HALF=3):
1. Reset, then hold 11.
   - Before the 4th edge: valid=0, segments=1111111, level_onehot=0000.
   - After the 4th edge: valid=1, level=11, segments=0110000, level_onehot=1000, changed high exactly one cycle.
2. From accepted 11, drive 10 for 3 edges, then back to 11 -> level stays 11, changed never asserts, segments unchanged.
3. From 11, drive 01 held -> after the 4th sample: level=01, segments=1111001, level_onehot=0010, changed pulse; alarm=0 throughout.
4. Drive 00 held -> on accept: alarm=1, level_onehot=0001.
   - segments then repeat 1000000 for 3 cycles, 1111111 for 3 cycles, across at least 3 periods.
   - alarm stays 1 constantly.
5. In Critical during a blank phase, drive 10 held 4 samples -> segments=0100100 immediately after accept, alarm=0.
   - Re-enter 00 -> blink restarts with a lit phase of a full 3 cycles.
6. Hold 10 for 2 samples post-reset, then assert reset between edges -> all outputs return to reset values without waiting for a clock edge.
   - After release, 10 needs 4 fresh samples before valid=1.

Source files
------------

// File: rtl/water_level_display.sv
// Display-side decoder for the 2-bit water level code: glitch filter, 7-segment drive,
// one-hot level lines, and a blinking digit with a steady alarm while the level is Critical.
module water_level_display #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned BLINK_HALF    = 25000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] encoded_water,
    output logic [6:0] segments,
    output logic [1:0] level,
    output logic [3:0] level_onehot,
    output logic       valid,
    output logic       changed,
    output logic       alarm
);

    localparam int unsigned RUN_W   = $clog2(STABLE_CYCLES) + 1;
    localparam int unsigned BLINK_W = $clog2(BLINK_HALF) + 1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_ONE   = 7'b1111001;
    localparam logic [6:0] SEG_TWO   = 7'b0100100;
    localparam logic [6:0] SEG_THREE = 7'b0110000;

    logic [1:0]         candidate;
    logic [RUN_W-1:0]   run;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;

    logic [RUN_W-1:0]   next_run;
    logic               accept;
    logic               critical;
    logic [BLINK_W-1:0] blink_cnt_next;
    logic               blink_phase_next;

    // Run-length filter and blink timer next-state
    always_comb begin
        next_run         = RUN_W'(1);
        accept           = 1'b0;
        blink_cnt_next   = '0;
        blink_phase_next = 1'b0;
        critical         = valid && (level == 2'b00);

        if (encoded_water == candidate) begin
            if (run >= RUN_W'(STABLE_CYCLES)) begin
                next_run = RUN_W'(STABLE_CYCLES);
            end else begin
                next_run = run + RUN_W'(1);
            end
        end

        accept = (next_run >= RUN_W'(STABLE_CYCLES)) && (!valid || (encoded_water != level));

        // Accept reloads the blink so a fresh Critical always starts with a full lit phase
        if (!accept && critical) begin
            if (blink_cnt == BLINK_W'(BLINK_HALF - 1)) begin
                blink_cnt_next   = '0;
                blink_phase_next = !blink_phase;
            end else begin
                blink_cnt_next   = blink_cnt + BLINK_W'(1);
                blink_phase_next = blink_phase;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            candidate   <= 2'b00;
            run         <= '0;
            level       <= 2'b00;
            valid       <= 1'b0;
            changed     <= 1'b0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            candidate   <= encoded_water;
            run         <= next_run;
            changed     <= accept;
            blink_cnt   <= blink_cnt_next;
            blink_phase <= blink_phase_next;
            if (accept) begin
                level <= encoded_water;
                valid <= 1'b1;
            end
        end
    end

    // Display decode from registered state
    always_comb begin
        segments     = SEG_BLANK;
        alarm        = valid && (level == 2'b00);
        level_onehot = valid ? (4'b0001 << level) : 4'b0000;
        if (valid) begin
            case (level)
                2'b00:   segments = blink_phase ? SEG_BLANK : SEG_ZERO;
                2'b01:   segments = SEG_ONE;
                2'b10:   segments = SEG_TWO;
                default: segments = SEG_THREE;
            endcase
        end
    end

endmodule
